// File: rtl/rom_burst_reader.sv
// Burst sequencer in front of a one-hot-addressed, registered-read ROM.
// Walks a wrap-around index range, buffers returned bytes in a 2-deep FIFO and streams them out.
module rom_burst_reader #(
  parameter int DATA_W      = 8,
  parameter int NUM_ENTRIES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [2:0]                 start_idx,
  input  logic [3:0]                 count,
  output logic                       busy,
  output logic                       rom_en,
  output logic [NUM_ENTRIES-1:0]     rom_addr,
  input  logic [DATA_W-1:0]          rom_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       done,
  output logic [DATA_W-1:0]          checksum
);

  // Stream handshake: a word transfers on every rising edge where out_valid
  // and out_ready are both 1; out_data holds steady while out_valid waits on out_ready.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic [2:0]  idx;
  logic [3:0]  remaining;
  logic [3:0]  issued;
  logic        inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  fifo_cnt;

  logic        start_accept;
  logic        push, pop;
  logic [2:0]  occupancy;
  logic        issue_ok;
  logic        burst_last;
  logic [3:0]  count_clamped;

  assign start_accept  = (state == IDLE) && start;
  assign count_clamped = (count > 4'd8) ? 4'd8 : count;
  assign push          = inflight;
  assign pop           = out_valid && out_ready;
  // Occupancy counts the slot reserved by a read still in flight, minus a word leaving now.
  assign occupancy     = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue_ok      = (state == RUN) && (issued < remaining) && (occupancy < 3'd2);
  assign burst_last    = (state == RUN) && (issued == remaining) && !inflight &&
                         (fifo_cnt == {1'b0, pop});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (count == 4'd0) ? FINISH : RUN;
      end
      RUN: begin
        if (burst_last) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state == RUN);
    done     = (state == FINISH);
    rom_en   = issue_ok;
    rom_addr = '0;
    if (issue_ok) rom_addr = NUM_ENTRIES'(1) << idx;
  end

  // Burst bookkeeping and checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      remaining <= '0;
      issued    <= '0;
      inflight  <= 1'b0;
      checksum  <= '0;
    end else begin
      inflight <= issue_ok;
      if (start_accept) begin
        idx       <= start_idx;
        remaining <= count_clamped;
        issued    <= '0;
        checksum  <= '0;
      end else begin
        if (issue_ok) begin
          idx    <= (idx == 3'(NUM_ENTRIES - 1)) ? 3'd0 : idx + 3'd1;
          issued <= issued + 4'd1;
        end
        if (pop) checksum <= checksum + out_data;
      end
    end
  end

  // Two-entry output FIFO; ROM data is captured the cycle after its read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rom_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];

endmodule
